// File: rtl/seg_scan_display.sv
// Multiplexed hex seven-segment scanner with tear-free display updates,
// optional leading-zero blanking and selectable output polarity.
module seg_scan_display #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_load,
  input  logic                  i_lz_en,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_dig,
  output logic                  o_frame
);

  localparam int   CNT_W = $clog2(SCAN_DIV);
  localparam int   IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic POL   = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic                tc;
  logic                wrap;
  logic                wrap_q;
  logic [4*DIGITS-1:0] stage_data;
  logic [DIGITS-1:0]   stage_dp;
  logic                pending;
  logic [4*DIGITS-1:0] disp_data;
  logic [DIGITS-1:0]   disp_dp;
  logic [3:0]          sel_nib;
  logic                nz_above;
  logic                blank;
  logic [6:0]          seg_pat;
  logic [DIGITS-1:0]   dig_onehot;

  // Active-high a..g pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tc   = (presc == CNT_W'(SCAN_DIV - 1));
  assign wrap = tc && (idx == IDX_W'(DIGITS - 1));

  // Prescaler and digit index: advance one digit per terminal count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (tc) begin
      presc <= '0;
      idx   <= wrap ? '0 : idx + IDX_W'(1);
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  // Staging/display registers: new values only reach the display at a frame wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stage_data <= '0;
      stage_dp   <= '0;
      pending    <= 1'b0;
      disp_data  <= '0;
      disp_dp    <= '0;
    end else if (wrap) begin
      // A load landing on the wrap itself bypasses staging entirely.
      if (i_load) begin
        disp_data <= i_data;
        disp_dp   <= i_dp;
      end else if (pending) begin
        disp_data <= stage_data;
        disp_dp   <= stage_dp;
      end
      pending <= 1'b0;
    end else if (i_load) begin
      stage_data <= i_data;
      stage_dp   <= i_dp;
      pending    <= 1'b1;
    end
  end

  // Select the current digit and decide whether it is a leading zero.
  always_comb begin
    sel_nib  = disp_data[4*int'(idx) +: 4];
    nz_above = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(idx)) && (disp_data[4*j +: 4] != 4'd0)) nz_above = 1'b1;
    end
    blank      = i_lz_en && (idx != '0) && !nz_above;
    seg_pat    = blank ? 7'h00 : hex_to_seg(sel_nib);
    dig_onehot = DIGITS'(1) << idx;
  end

  // Registered, polarity-adjusted outputs; frame pulse lines up with digit 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_seg   <= {7{POL}};
      o_dp    <= POL;
      o_dig   <= {DIGITS{POL}};
      o_frame <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      o_seg   <= seg_pat ^ {7{POL}};
      o_dp    <= disp_dp[idx] ^ POL;
      o_dig   <= dig_onehot ^ {DIGITS{POL}};
      o_frame <= wrap_q;
      wrap_q  <= wrap;
    end
  end

endmodule
